// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - key-selected seven-segment source mux with timed hold, reverting to channel 0
// Optional hold-mode digit blink is built only when DISPLAY_ARB_BLINK_EN is defined.
module display_source_arbiter #(
    parameter int N_SRC       = 3,
    parameter int TIMEOUT_CYC = 1000000000,
    parameter int BLINK_HALF  = 50000000,
    localparam int IDX_W      = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 power_on,
    input  logic [N_SRC-1:0]     src_req,
    input  logic [8*N_SRC-1:0]   seg_a_in,
    input  logic [8*N_SRC-1:0]   seg_b_in,
    input  logic [8*N_SRC-1:0]   dig_sel_in,
    output logic [7:0]           seg_a,
    output logic [7:0]           seg_b,
    output logic [7:0]           dig_sel,
    output logic [IDX_W-1:0]     active_src,
    output logic                 hold_active
);
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {ST_BLANK, ST_DEFAULT, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [N_SRC-1:0]   req_q, req_d;
    logic [7:0]         seg_a_q, seg_a_d, seg_b_q, seg_b_d, dig_q, dig_d;
    logic [N_SRC-1:0]   rise;
    logic [IDX_W-1:0]   rise_idx;
    int                 n_rise;
    logic               restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BLANK;
            sel_q   <= '0;
            tmr_q   <= '0;
            req_q   <= '0;
            seg_a_q <= '0;
            seg_b_q <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tmr_q   <= tmr_d;
            req_q   <= req_d;
            seg_a_q <= seg_a_d;
            seg_b_q <= seg_b_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        req_d    = src_req;
        rise     = src_req & ~req_q;
        n_rise   = $countones(rise);
        rise_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (rise[k]) rise_idx = IDX_W'(k);
        end
        state_d = state_q;
        sel_d   = sel_q;
        tmr_d   = tmr_q;
        restart = 1'b0;
        case (state_q)
            ST_BLANK: begin
                sel_d = '0;
                tmr_d = '0;
                if (power_on) state_d = ST_DEFAULT;
            end
            default: begin
                if (!power_on) begin
                    state_d = ST_BLANK;
                    sel_d   = '0;
                    tmr_d   = '0;
                end else if (n_rise > 1 || (n_rise == 1 && rise_idx == '0)) begin
                    state_d = ST_DEFAULT;
                    sel_d   = '0;
                    tmr_d   = '0;
                end else if (n_rise == 1) begin
                    // A rise on the channel already held restarts its hold window.
                    state_d = ST_HOLD;
                    sel_d   = rise_idx;
                    tmr_d   = '0;
                    restart = 1'b1;
                end else if (state_q == ST_HOLD) begin
                    if (TIMEOUT_CYC != 0 && tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_d = ST_DEFAULT;
                        sel_d   = '0;
                        tmr_d   = '0;
                    end else if (tmr_q != '1) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef DISPLAY_ARB_BLINK_EN
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_off_q, blink_off_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == ST_HOLD && !restart) begin
            if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_off_d = blink_off_q;
            end
        end
    end
`endif

    always_comb begin
        seg_a_d = '0;
        seg_b_d = '0;
        dig_d   = '0;
        if (state_q != ST_BLANK) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (sel_q == IDX_W'(k)) begin
                    seg_a_d = seg_a_in[8*k +: 8];
                    seg_b_d = seg_b_in[8*k +: 8];
                    dig_d   = dig_sel_in[8*k +: 8];
                end
            end
        end
`ifdef DISPLAY_ARB_BLINK_EN
        if (state_q == ST_HOLD && blink_off_q) dig_d = '0;
`endif
    end

    assign seg_a       = seg_a_q;
    assign seg_b       = seg_b_q;
    assign dig_sel     = dig_q;
    assign active_src  = sel_q;
    assign hold_active = (state_q == ST_HOLD);
endmodule

// File: tb/tb_display_source_arbiter.sv
// tb/tb_display_source_arbiter.sv - scoreboard bench for display_source_arbiter against a cycle-indexed reference model
module tb_display_source_arbiter;
    localparam int NS = 3;
    localparam int TO = 16;
    localparam int BH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            power_on = 1'b0;
    logic [NS-1:0]   src_req = '0;
    logic [8*NS-1:0] seg_a_in, seg_b_in, dig_sel_in;
    logic [7:0]      seg_a, seg_b, dig_sel;
    logic [1:0]      active_src;
    logic            hold_active;

    logic [7:0] sa [NS];
    logic [7:0] sb [NS];
    logic [7:0] dg [NS];

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            seg_a_in[8*k +: 8]   = sa[k];
            seg_b_in[8*k +: 8]   = sb[k];
            dig_sel_in[8*k +: 8] = dg[k];
        end
    end

    display_source_arbiter #(.N_SRC(NS), .TIMEOUT_CYC(TO), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset), .power_on(power_on), .src_req(src_req),
        .seg_a_in(seg_a_in), .seg_b_in(seg_b_in), .dig_sel_in(dig_sel_in),
        .seg_a(seg_a), .seg_b(seg_b), .dig_sel(dig_sel),
        .active_src(active_src), .hold_active(hold_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [1:0] act;
        logic       hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: shown/not, channel held, and the cycle number at which the hold began.
    bit        m_on = 0;
    int        m_ch = 0;
    int        m_entry = 0;
    int        cyc = 0;
    bit [NS-1:0] m_prev = '0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        bit [NS-1:0] r;
        int nr;
        int k1;
        e.a = m_on ? sa[m_ch] : 8'h00;
        e.b = m_on ? sb[m_ch] : 8'h00;
        e.d = m_on ? dg[m_ch] : 8'h00;
`ifdef DISPLAY_ARB_BLINK_EN
        if (m_on && m_ch != 0 && (((cyc - m_entry - 1) / BH) % 2) == 1) e.d = 8'h00;
`endif
        r = src_req & ~m_prev;
        m_prev = src_req;
        nr = 0;
        k1 = 0;
        for (int k = 0; k < NS; k++) if (r[k]) begin nr++; k1 = k; end
        if (!m_on) begin
            if (power_on) m_on = 1;
            m_ch = 0;
        end else if (!power_on) begin
            m_on = 0;
            m_ch = 0;
        end else if (nr >= 2 || (nr == 1 && k1 == 0)) begin
            m_ch = 0;
        end else if (nr == 1) begin
            m_ch = k1;
            m_entry = cyc;
        end else if (m_ch != 0 && cyc - m_entry == TO) begin
            m_ch = 0;
        end
        e.act  = 2'(m_ch);
        e.hold = (m_ch != 0);
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_seg_a", seg_a, 8'h00);
        chk("rst_seg_b", seg_b, 8'h00);
        chk("rst_dig_sel", dig_sel, 8'h00);
        chk("rst_active_src", {6'b0, active_src}, 8'h00);
        chk("rst_hold_active", {7'b0, hold_active}, 8'h00);
        exp_q.delete();
        m_on = 0;
        m_ch = 0;
        m_prev = '0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_a", seg_a, e.a);
                chk("seg_b", seg_b, e.b);
                chk("dig_sel", dig_sel, e.d);
                chk("active_src", {6'b0, active_src}, {6'b0, e.act});
                chk("hold_active", {7'b0, hold_active}, {7'b0, e.hold});
            end
        end
    end

    initial begin
        for (int k = 0; k < NS; k++) begin
            sa[k] = 8'h10 + 8'(k);
            sb[k] = 8'h20 + 8'(k);
            dg[k] = 8'h01 << k;
        end
        #2;
        do_reset();
        power_on = 1'b0;
        repeat (3) step();
        power_on = 1'b1;
        repeat (3) step();
        src_req = 3'b100; step(); src_req = 3'b000;
        repeat (20) step();
        src_req = 3'b010; step(); src_req = 3'b000;
        repeat (9) step();
        src_req = 3'b010;
        repeat (25) step();
        src_req = 3'b000; step();
        src_req = 3'b010; step(); src_req = 3'b000;
        repeat (3) step();
        src_req = 3'b110;
        repeat (4) step();
        src_req = 3'b000; step();
        src_req = 3'b100; step(); src_req = 3'b000;
        repeat (3) step();
        power_on = 1'b0;
        repeat (3) step();
        power_on = 1'b1;
        repeat (3) step();
        src_req = 3'b100; step(); src_req = 3'b000;
        repeat (3) step();
        do_reset();
        power_on = 1'b1;
        repeat (600) begin
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 15) == 0) src_req[k] = ~src_req[k];
                if ($urandom_range(0, 7) == 0) sa[k] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) sb[k] = 8'($urandom);
                if ($urandom_range(0, 7) == 0) dg[k] = 8'($urandom);
            end
            if ($urandom_range(0, 63) == 0) power_on = ~power_on;
            step();
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
